// File: rtl/mc_control.sv
// Multi-cycle MIPS-style control unit: Moore FSM with memory-wait trap and retired counter.
// Optional JUMP_EN macro enables the j (opcode 000010) path through the JUMP state.
module mc_control #(
  parameter int ALUOP_W  = 3,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               RegDest,
  output logic               Branch,
  output logic               BranchNe,
  output logic               MemRead,
  output logic               MemtoReg,
  output logic               MemWrite,
  output logic               ALUSrc,
  output logic               RegWrite,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [3:0]         state,
  output logic               trap,
  output logic [CNT_W-1:0]   retired
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEM_ADDR = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_MEM_WB   = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_R_EXEC   = 4'd6;
  localparam logic [3:0] S_R_WB     = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_I_EXEC   = 4'd9;
  localparam logic [3:0] S_I_WB     = 4'd10;
  localparam logic [3:0] S_TRAP     = 4'd11;
  localparam logic [3:0] S_JUMP     = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;

  localparam int WCNT_W = $clog2(WAIT_MAX + 1);

  logic [3:0]        state_q;
  logic [3:0]        next_state;
  logic [5:0]        op_q;
  logic [WCNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  retired_q;
  logic              wait_hit;
  logic              mem_wait;
  logic [2:0]        alu_op3;

  // The current low cycle is the WAIT_MAX-th one, so it must trap now.
  assign wait_hit = (wait_cnt == WCNT_W'(WAIT_MAX - 1));
  assign mem_wait = ((state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                     (state_q == S_MEM_WR)) && !mem_ready;

  always_comb begin
    next_state = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)     next_state = S_DECODE;
        else if (wait_hit) next_state = S_TRAP;
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:                  next_state = S_R_EXEC;
          OP_ADDI, OP_ANDI, OP_ORI:  next_state = S_I_EXEC;
          OP_LW, OP_SW:              next_state = S_MEM_ADDR;
          OP_BEQ, OP_BNE:            next_state = S_BRANCH;
`ifdef JUMP_EN
          OP_J:                      next_state = S_JUMP;
`endif
          default:                   next_state = S_TRAP;
        endcase
      end
      S_MEM_ADDR: next_state = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (mem_ready)     next_state = S_MEM_WB;
        else if (wait_hit) next_state = S_TRAP;
      end
      S_MEM_WB: next_state = S_FETCH;
      S_MEM_WR: begin
        if (mem_ready)     next_state = S_FETCH;
        else if (wait_hit) next_state = S_TRAP;
      end
      S_R_EXEC: next_state = S_R_WB;
      S_R_WB:   next_state = S_FETCH;
      S_BRANCH: next_state = S_FETCH;
      S_I_EXEC: next_state = S_I_WB;
      S_I_WB:   next_state = S_FETCH;
      S_TRAP:   next_state = S_TRAP;
      S_JUMP:   next_state = S_FETCH;
      default:  next_state = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      op_q      <= 6'd0;
      wait_cnt  <= '0;
      retired_q <= '0;
    end else begin
      state_q <= next_state;
      if (state_q == S_DECODE) op_q <= opcode;
      if (next_state != state_q) wait_cnt <= '0;
      else if (mem_wait)         wait_cnt <= wait_cnt + 1'b1;
      // Every non-FETCH state that returns to FETCH is the last step of an instruction.
      if ((next_state == S_FETCH) && (state_q != S_FETCH))
        retired_q <= retired_q + 1'b1;
    end
  end

  always_comb begin
    RegDest  = 1'b0;
    Branch   = 1'b0;
    BranchNe = 1'b0;
    MemRead  = 1'b0;
    MemtoReg = 1'b0;
    MemWrite = 1'b0;
    ALUSrc   = 1'b0;
    RegWrite = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    alu_op3  = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        PCWrite = 1'b1;
      end
      S_MEM_ADDR: ALUSrc = 1'b1;
      S_MEM_RD:   MemRead = 1'b1;
      S_MEM_WB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEM_WR:   MemWrite = 1'b1;
      S_R_EXEC:   alu_op3 = ALU_FUNCT;
      S_R_WB: begin
        RegDest  = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        alu_op3  = ALU_SUB;
        Branch   = 1'b1;
        BranchNe = (op_q == OP_BNE);
      end
      S_I_EXEC: begin
        ALUSrc = 1'b1;
        case (op_q)
          OP_ANDI: alu_op3 = ALU_AND;
          OP_ORI:  alu_op3 = ALU_OR;
          default: alu_op3 = ALU_ADD;
        endcase
      end
      S_I_WB:   RegWrite = 1'b1;
      S_JUMP:   PCWrite = 1'b1;
      default: ;
    endcase
  end

  assign ALUOp   = ALUOP_W'(alu_op3);
  assign state   = state_q;
  assign trap    = (state_q == S_TRAP);
  assign retired = retired_q;

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: per-instruction state/control traces built from the ISA rules.
module tb_mc_control;

  localparam int ALUOP_W  = 4;
  localparam int WAIT_MAX = 15;
  localparam int CNT_W    = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [5:0]         opcode;
  logic               mem_ready;
  logic               RegDest, Branch, BranchNe, MemRead, MemtoReg, MemWrite;
  logic               ALUSrc, RegWrite, IRWrite, PCWrite;
  logic [ALUOP_W-1:0] ALUOp;
  logic [3:0]         state;
  logic               trap;
  logic [CNT_W-1:0]   retired;

  mc_control #(.ALUOP_W(ALUOP_W), .WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .RegDest(RegDest), .Branch(Branch), .BranchNe(BranchNe), .MemRead(MemRead),
    .MemtoReg(MemtoReg), .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .ALUOp(ALUOp), .state(state),
    .trap(trap), .retired(retired)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  // scoreboard: expected state per cycle and the mem_ready to drive in that cycle
  logic [3:0]       exp_q[$];
  logic             mr_q[$];
  logic [5:0]       cur_op;
  logic [CNT_W-1:0] exp_ret;

  logic [13:0] got_ctrl;
  assign got_ctrl = {RegDest, Branch, BranchNe, MemRead, MemtoReg, MemWrite,
                     ALUSrc, RegWrite, IRWrite, PCWrite, ALUOp};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected controls, as listed for each state in the ISA control table.
  function automatic logic [13:0] exp_ctrl(input logic [3:0] st, input logic [5:0] op);
    logic rd, br, bne, mrd, m2r, mwr, src, rw, irw, pcw;
    logic [3:0] alu;
    {rd, br, bne, mrd, m2r, mwr, src, rw, irw, pcw} = '0;
    alu = 4'd0;
    case (st)
      4'd0:  begin mrd = 1; irw = 1; pcw = 1; alu = 4'd0; end
      4'd2:  begin src = 1; alu = 4'd0; end
      4'd3:  mrd = 1;
      4'd4:  begin m2r = 1; rw = 1; end
      4'd5:  mwr = 1;
      4'd6:  begin src = 0; alu = 4'd2; end
      4'd7:  begin rd = 1; rw = 1; end
      4'd8:  begin alu = 4'd1; br = 1; bne = (op == 6'b000101); end
      4'd9:  begin
        src = 1;
        if (op == 6'b001100)      alu = 4'd3;
        else if (op == 6'b001101) alu = 4'd4;
        else                      alu = 4'd0;
      end
      4'd10: rw = 1;
      4'd12: pcw = 1;
      default: ;
    endcase
    return {rd, br, bne, mrd, m2r, mwr, src, rw, irw, pcw, alu};
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // A memory-handshake state: w low cycles then one ready cycle, or trap after WAIT_MAX lows.
  task automatic push_mem(input logic [3:0] st, input int w, output logic trapped);
    trapped = 1'b0;
    if (w >= WAIT_MAX) begin
      for (int i = 0; i < WAIT_MAX; i++) begin exp_q.push_back(st); mr_q.push_back(1'b0); end
      trapped = 1'b1;
    end else begin
      for (int i = 0; i < w; i++) begin exp_q.push_back(st); mr_q.push_back(1'b0); end
      exp_q.push_back(st); mr_q.push_back(1'b1);
    end
  endtask

  task automatic push_st(input logic [3:0] st);
    exp_q.push_back(st);
    mr_q.push_back(rnd_bit());
  endtask

  // Returns 1 if the instruction ends in TRAP; trap is followed by a few hold cycles.
  task automatic build_instr(input logic [5:0] op, input int fw, input int mw, output logic trapped);
    push_mem(4'd0, fw, trapped);
    if (!trapped) begin
      push_st(4'd1);
      case (op)
        6'b000000: begin push_st(4'd6); push_st(4'd7); end
        6'b001000, 6'b001100, 6'b001101: begin push_st(4'd9); push_st(4'd10); end
        6'b100011: begin
          push_st(4'd2);
          push_mem(4'd3, mw, trapped);
          if (!trapped) push_st(4'd4);
        end
        6'b101011: begin push_st(4'd2); push_mem(4'd5, mw, trapped); end
        6'b000100, 6'b000101: push_st(4'd8);
`ifdef JUMP_EN
        6'b000010: push_st(4'd12);
`endif
        default: trapped = 1'b1;
      endcase
    end
    if (trapped)
      for (int i = 0; i < 5; i++) push_st(4'd11);
  endtask

  // driver: called just after a rising edge; drives one cycle per queued entry and checks outputs
  task automatic run_q();
    logic [3:0] st;
    while (exp_q.size() > 0) begin
      st = exp_q.pop_front();
      mem_ready = mr_q.pop_front();
      opcode = (st == 4'd1) ? cur_op : 6'($urandom_range(0, 63));
      #1;
      check("state", 32'(state), 32'(st));
      check("ctrl", 32'(got_ctrl), 32'(exp_ctrl(st, cur_op)));
      check("trap", 32'(trap), 32'(st == 4'd11));
      check("retired", 32'(retired), 32'(exp_ret));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    logic trapped;
    cur_op = op;
    build_instr(op, fw, mw, trapped);
    run_q();
    if (!trapped) exp_ret = exp_ret + 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_trap", 32'(trap), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    check("rst_ctrl", 32'(got_ctrl), 32'(exp_ctrl(4'd0, 6'd0)));
    exp_ret = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [5:0] ops [9] = '{6'b000000, 6'b001000, 6'b001100, 6'b001101, 6'b100011,
                          6'b101011, 6'b000100, 6'b000101, 6'b000000};

  initial begin
    rst = 1'b1;
    mem_ready = 1'b0;
    opcode = 6'd0;
    exp_ret = '0;
    cur_op = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // add, lw with 3 wait cycles, bne, beq, and immediates
    run_instr(6'b000000, 0, 0);
    run_instr(6'b100011, 0, 3);
    run_instr(6'b000101, 0, 0);
    run_instr(6'b000100, 1, 0);
    run_instr(6'b001100, 0, 0);
    run_instr(6'b001101, 2, 0);
    run_instr(6'b101011, 0, 14);

    // random instruction mix; enough retirements to wrap the narrow counter
    for (int n = 0; n < 40; n++)
      run_instr(ops[$urandom_range(0, 8)], $urandom_range(0, 2), $urandom_range(0, 14));

    // reset asynchronously in the middle of a stalled store
    cur_op = 6'b101011;
    push_st(4'd0); mr_q[0] = 1'b1;
    push_st(4'd1); push_st(4'd2);
    exp_q.push_back(4'd5); mr_q.push_back(1'b0);
    exp_q.push_back(4'd5); mr_q.push_back(1'b0);
    run_q();
    check("sw_stall_memwrite", 32'(MemWrite), 32'd1);
    check("sw_stall_state", 32'(state), 32'd5);
    do_reset();

    // fetch timeout right after reset: exactly WAIT_MAX low cycles to trap
    run_instr(6'b000000, WAIT_MAX, 0);
    do_reset();

    // store timeout
    run_instr(6'b101011, 0, WAIT_MAX);
    do_reset();

    // illegal opcode
    run_instr(6'b111111, 0, 0);
    do_reset();

    // jump: JUMP state when enabled, trap otherwise
    run_instr(6'b000010, 0, 0);
    do_reset();

    run_instr(6'b001000, 0, 0);
    run_instr(6'b000000, 0, 0);
    #1;
    check("final_retired", 32'(retired), 32'(exp_ret));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
